// File: rtl/store_queue.sv
// Store queue: in-order dispatch, out-of-order completion, in-order retire and memory drain.
// Build with SQ_FORWARD_EN defined for store-to-load forwarding; without it loads stall instead.
module store_queue #(
    parameter int unsigned SIZE           = 8,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned RETIRE_WIDTH   = 2,
    parameter int unsigned ROB_IDX_W      = 5,
    localparam int unsigned IDX_W         = $clog2(SIZE)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [DISPATCH_WIDTH-1:0]           disp_valid,
    input  logic [DISPATCH_WIDTH*ROB_IDX_W-1:0] disp_rob_idx,
    output logic                                disp_ready,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]     disp_sq_idx,
    input  logic                                cmpl_valid,
    input  logic [IDX_W-1:0]                    cmpl_sq_idx,
    input  logic [31:0]                         cmpl_addr,
    input  logic [31:0]                         cmpl_data,
    input  logic [3:0]                          cmpl_mask,
    input  logic [RETIRE_WIDTH-1:0]             ret_valid,
    input  logic                                flush,
    output logic                                mem_valid,
    output logic [31:0]                         mem_addr,
    output logic [31:0]                         mem_data,
    output logic [3:0]                          mem_mask,
    input  logic                                mem_accepted,
    input  logic                                ld_valid,
    input  logic [31:0]                         ld_addr,
    input  logic [IDX_W-1:0]                    ld_sq_idx,
    output logic                                fwd_hit,
    output logic [31:0]                         fwd_data,
    output logic                                fwd_stall,
    output logic [IDX_W:0]                      count
);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {StEmpty, StDispatched, StCompleted, StRetired} entry_state_e;

    entry_state_e state_q [SIZE];
    entry_state_e state_d [SIZE];
    logic [31:0]  addr_q  [SIZE];
    logic [31:0]  addr_d  [SIZE];
    logic [31:0]  data_q  [SIZE];
    logic [31:0]  data_d  [SIZE];
    logic [3:0]   mask_q  [SIZE];
    logic [3:0]   mask_d  [SIZE];
    logic [SIZE-1:0][ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;

    logic [PTR_W-1:0] head_q, head_d, ret_ptr_q, ret_ptr_d, tail_q, tail_d, count_q, count_d;
    logic [PTR_W-1:0] lane_ptr [DISPATCH_WIDTH];
    logic [PTR_W-1:0] disp_cnt, ret_cnt, ret_slot;
    logic [IDX_W-1:0] head_idx, ld_dist;
    logic             unused_sig;

    assign head_idx   = head_q[IDX_W-1:0];
    assign disp_ready = (PTR_W'(SIZE) - count_q) >= PTR_W'(DISPATCH_WIDTH);
    assign count      = count_q;
    assign mem_valid  = (state_q[head_idx] == StRetired);
    assign mem_addr   = addr_q[head_idx];
    assign mem_data   = data_q[head_idx];
    assign mem_mask   = mask_q[head_idx];
    assign ld_dist    = ld_sq_idx - head_idx;
    // ROB tags are kept for debug visibility only; word-offset address bits never take part.
    assign unused_sig = ^{rob_idx_q, ld_addr[1:0]};

    // Each valid lane takes the next free slot after the lanes below it.
    always_comb begin
        disp_sq_idx = '0;
        disp_cnt    = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            lane_ptr[i] = tail_q + disp_cnt;
            disp_sq_idx[i*IDX_W +: IDX_W] = lane_ptr[i][IDX_W-1:0];
            if (disp_valid[i]) disp_cnt = disp_cnt + PTR_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        rob_idx_d = rob_idx_q;
        head_d    = head_q;
        ret_ptr_d = ret_ptr_q;
        tail_d    = tail_q;
        ret_cnt   = '0;
        ret_slot  = '0;
        if (!flush) begin
            if (disp_ready) begin
                for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                    if (disp_valid[i]) begin
                        state_d[lane_ptr[i][IDX_W-1:0]]   = StDispatched;
                        rob_idx_d[lane_ptr[i][IDX_W-1:0]] = disp_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    end
                end
                tail_d = tail_q + disp_cnt;
            end
            if (cmpl_valid && state_q[cmpl_sq_idx] == StDispatched) begin
                state_d[cmpl_sq_idx] = StCompleted;
                addr_d[cmpl_sq_idx]  = cmpl_addr;
                data_d[cmpl_sq_idx]  = cmpl_data;
                mask_d[cmpl_sq_idx]  = cmpl_mask;
            end
            for (int j = 0; j < RETIRE_WIDTH; j++) begin
                ret_slot = ret_ptr_q + ret_cnt;
                if (ret_valid[j]) begin
                    state_d[ret_slot[IDX_W-1:0]] = StRetired;
                    ret_cnt = ret_cnt + PTR_W'(1);
                end
            end
            ret_ptr_d = ret_ptr_q + ret_cnt;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (state_q[i] != StRetired) state_d[i] = StEmpty;
            end
            tail_d = ret_ptr_q;
        end
        // The head entry is always RETIRED when it drains, so flush never collides with it.
        if (mem_valid && mem_accepted) begin
            state_d[head_idx] = StEmpty;
            head_d = head_q + PTR_W'(1);
        end
        count_d = tail_d - head_d;
    end

`ifdef SQ_FORWARD_EN
    logic             fwd_match, fwd_pend;
    logic [3:0]       fwd_mask;
    logic [31:0]      fwd_word;
    logic [IDX_W-1:0] fwd_slot;

    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        fwd_stall = 1'b0;
        fwd_match = 1'b0;
        fwd_pend  = 1'b0;
        fwd_mask  = '0;
        fwd_word  = '0;
        fwd_slot  = '0;
        // Later iterations are younger, so the last match wins.
        for (int j = 0; j < SIZE; j++) begin
            fwd_slot = head_idx + IDX_W'(j);
            if (IDX_W'(j) < ld_dist) begin
                if (state_q[fwd_slot] == StDispatched) begin
                    fwd_pend = 1'b1;
                end else if (state_q[fwd_slot] != StEmpty &&
                             addr_q[fwd_slot][31:2] == ld_addr[31:2]) begin
                    fwd_match = 1'b1;
                    fwd_mask  = mask_q[fwd_slot];
                    fwd_word  = data_q[fwd_slot];
                end
            end
        end
        if (ld_valid) begin
            fwd_stall = fwd_pend | (fwd_match & (fwd_mask != 4'hF));
            fwd_hit   = fwd_match & (fwd_mask == 4'hF) & ~fwd_pend;
            for (int b = 0; b < 4; b++) begin
                if (fwd_match && fwd_mask[b]) fwd_data[b*8 +: 8] = fwd_word[b*8 +: 8];
            end
        end
    end
`else
    logic             older_busy;
    logic [IDX_W-1:0] fwd_slot;
    logic [31:0]      unused_ld_addr;

    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
    assign fwd_stall      = ld_valid & older_busy;
    assign unused_ld_addr = ld_addr;

    always_comb begin
        older_busy = 1'b0;
        fwd_slot   = '0;
        for (int j = 0; j < SIZE; j++) begin
            fwd_slot = head_idx + IDX_W'(j);
            if (IDX_W'(j) < ld_dist && state_q[fwd_slot] != StEmpty) older_busy = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) state_q[i] <= StEmpty;
            head_q    <= '0;
            ret_ptr_q <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            ret_ptr_q <= ret_ptr_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Payload is qualified by entry state, so it needs no reset.
    always_ff @(posedge clock) begin
        addr_q    <= addr_d;
        data_q    <= data_d;
        mask_q    <= mask_d;
        rob_idx_q <= rob_idx_d;
    end
endmodule

// File: tb/tb_store_queue.sv
// Directed self-checking bench for store_queue (default parameters, SIZE=8, two lanes each).
module tb_store_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  disp_valid;
    logic [9:0]  disp_rob_idx;
    logic        disp_ready;
    logic [5:0]  disp_sq_idx;
    logic        cmpl_valid;
    logic [2:0]  cmpl_sq_idx;
    logic [31:0] cmpl_addr;
    logic [31:0] cmpl_data;
    logic [3:0]  cmpl_mask;
    logic [1:0]  ret_valid;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_mask;
    logic        mem_accepted;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_sq_idx;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    int w;

    store_queue dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_rob_idx(disp_rob_idx),
        .disp_ready(disp_ready), .disp_sq_idx(disp_sq_idx),
        .cmpl_valid(cmpl_valid), .cmpl_sq_idx(cmpl_sq_idx), .cmpl_addr(cmpl_addr),
        .cmpl_data(cmpl_data), .cmpl_mask(cmpl_mask),
        .ret_valid(ret_valid), .flush(flush),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_mask(mem_mask), .mem_accepted(mem_accepted),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sq_idx(ld_sq_idx),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid   = '0;
        disp_rob_idx = '0;
        cmpl_valid   = 1'b0;
        cmpl_sq_idx  = '0;
        cmpl_addr    = '0;
        cmpl_data    = '0;
        cmpl_mask    = '0;
        ret_valid    = '0;
        flush        = 1'b0;
        ld_valid     = 1'b0;
        ld_addr      = '0;
        ld_sq_idx    = '0;
    endtask

    task automatic complete(input logic [2:0] slot, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        cmpl_valid  = 1'b1;
        cmpl_sq_idx = slot;
        cmpl_addr   = a;
        cmpl_data   = d;
        cmpl_mask   = m;
        step();
        cmpl_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] idx);
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_sq_idx = idx;
        #1;
    endtask

    initial begin
        idle();
        mem_accepted = 1'b0;
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_disp_ready", 32'(disp_ready), 1);
        check("rst_fwd_hit", 32'(fwd_hit), 0);
        check("rst_fwd_stall", 32'(fwd_stall), 0);
        check("rst_fwd_data", fwd_data, 0);

        // Fill: two stores per cycle land in slots 0..7.
        for (int c = 0; c < 4; c++) begin
            disp_valid   = 2'b11;
            disp_rob_idx = 10'(c * 66);
            #1;
            check("fill_idx", 32'(disp_sq_idx), 32'(((2 * c + 1) << 3) | (2 * c)));
            check("fill_ready", 32'(disp_ready), 1);
            step();
        end
        check("full_count", 32'(count), 8);
        check("full_ready", 32'(disp_ready), 0);
        step();
        check("full_ignored", 32'(count), 8);
        disp_valid = '0;

        // Complete, retire, drain slot 0.
        complete(3'd0, 32'h100, 32'hDEADBEEF, 4'hF);
        ret_valid    = 2'b01;
        mem_accepted = 1'b1;
        #1;
        check("pre_ret_mem_valid", 32'(mem_valid), 0);
        step();
        ret_valid = '0;
        check("drain_valid", 32'(mem_valid), 1);
        check("drain_addr", mem_addr, 32'h100);
        check("drain_data", mem_data, 32'hDEADBEEF);
        check("drain_mask", 32'(mem_mask), 32'hF);
        step();
        check("drain_count", 32'(count), 7);
        check("drain_next_idle", 32'(mem_valid), 0);

        // Reset while a write is pending drops it.
        mem_accepted = 1'b0;
        complete(3'd1, 32'h104, 32'h12345678, 4'hF);
        ret_valid = 2'b01;
        step();
        ret_valid = '0;
        check("hold_valid", 32'(mem_valid), 1);
        check("hold_addr", mem_addr, 32'h104);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_mem_valid", 32'(mem_valid), 0);
        check("midrst_count", 32'(count), 0);

        // Flush with three retired and two dispatched entries.
        disp_valid = 2'b11; step();
        disp_valid = 2'b11; step();
        disp_valid = 2'b01;
        #1;
        check("flush_fill_idx", 32'(disp_sq_idx[2:0]), 4);
        step();
        disp_valid = '0;
        check("flush_pre_count", 32'(count), 5);
        for (int i = 0; i < 3; i++) complete(3'(i), 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        ret_valid = 2'b11; step();
        ret_valid = 2'b01; step();
        flush        = 1'b1;
        disp_valid   = 2'b11;
        cmpl_valid   = 1'b1;
        cmpl_sq_idx  = 3'd3;
        cmpl_addr    = 32'h999;
        ret_valid    = 2'b01;
        step();
        idle();
        #1;
        check("flush_count", 32'(count), 3);
        check("flush_tail", 32'(disp_sq_idx[2:0]), 3);
        mem_accepted = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("flush_drain_valid", 32'(mem_valid), 1);
            check("flush_drain_addr", mem_addr, 32'h40 + 32'(4 * i));
            check("flush_drain_data", mem_data, 32'hA0 + 32'(i));
            step();
        end
        check("flush_done_valid", 32'(mem_valid), 0);
        check("flush_done_count", 32'(count), 0);
        mem_accepted = 1'b0;

        // Forwarding lookups: head = tail = 3 here.
        disp_valid = 2'b11;
        #1;
        check("fwd_disp_idx", 32'(disp_sq_idx), 32'h23);
        step();
        disp_valid = 2'b01; step();
        disp_valid = 2'b01; step();
        disp_valid = '0;
        complete(3'd3, 32'h200, 32'h11111111, 4'hF);
        complete(3'd4, 32'h200, 32'h22222222, 4'hF);
        complete(3'd5, 32'h300, 32'hAAAA5555, 4'h3);
        check("fwd_count", 32'(count), 4);
        load(32'h200, 3'd5);
`ifdef SQ_FORWARD_EN
        check("ld200_hit", 32'(fwd_hit), 1);
        check("ld200_data", fwd_data, 32'h22222222);
        check("ld200_stall", 32'(fwd_stall), 0);
`else
        check("ld200_hit", 32'(fwd_hit), 0);
        check("ld200_data", fwd_data, 0);
        check("ld200_stall", 32'(fwd_stall), 1);
`endif
        load(32'h300, 3'd6);
        check("ld300_stall", 32'(fwd_stall), 1);
        check("ld300_hit", 32'(fwd_hit), 0);
        load(32'h200, 3'd3);
        check("ld_empty_stall", 32'(fwd_stall), 0);
        check("ld_empty_hit", 32'(fwd_hit), 0);
        load(32'h400, 3'd7);
        check("ld_pend_stall", 32'(fwd_stall), 1);
        check("ld_pend_hit", 32'(fwd_hit), 0);
        ld_valid = 1'b0;
        #1;
        check("ld_idle_stall", 32'(fwd_stall), 0);

        // Streaming: dispatch, complete, retire and drain all overlap across three wraps.
        do_reset();
        mem_accepted = 1'b1;
        w = 0;
        for (int n = 0; n < 28; n++) begin
            idle();
            if (n < 24) disp_valid = 2'b01;
            if (n >= 1 && n <= 24) begin
                cmpl_valid  = 1'b1;
                cmpl_sq_idx = 3'((n - 1) % 8);
                cmpl_addr   = 32'h1000 + 32'(4 * (n - 1));
                cmpl_data   = 32'hC0DE0000 + 32'(n - 1);
                cmpl_mask   = 4'hF;
            end
            if (n >= 2 && n <= 25) ret_valid = 2'b01;
            #1;
            if (n < 24) check("wrap_slot", 32'(disp_sq_idx[2:0]), 32'(n % 8));
            if (mem_valid) begin
                check("wrap_addr", mem_addr, 32'h1000 + 32'(4 * w));
                check("wrap_data", mem_data, 32'hC0DE0000 + 32'(w));
                w++;
            end
            step();
        end
        idle();
        check("wrap_writes", 32'(w), 24);
        check("wrap_count", 32'(count), 0);
        check("wrap_idle", 32'(mem_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter SIZE, default 8: entries, power of two, at least 4.
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 2: store-dispatch lanes per cycle.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 2: store-retire lanes per cycle.
REQ-004 SHALL have parameter ROB_IDX_W, default 5: ROB index width; IDX_W = log2(SIZE).
REQ-005 SHALL have ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- disp_valid  in  DISPATCH_WIDTH  per-lane store dispatch.
- disp_rob_idx  in  DISPATCH_WIDTH*ROB_IDX_W  ROB tag per lane.
- disp_ready  out  1  free entries >= DISPATCH_WIDTH.
- disp_sq_idx  out  DISPATCH_WIDTH*IDX_W  slot allocated per lane.
- cmpl_valid  in  1  address/data resolved.
- cmpl_sq_idx  in  IDX_W  completing slot.
- cmpl_addr  in  32  byte address.
- cmpl_data  in  32  store data.
- cmpl_mask  in  4  byte enables.
- ret_valid  in  RETIRE_WIDTH  retire lanes, contiguous from lane 0.
- flush  in  1  squash all non-retired entries.
- mem_valid  out  1  write request.
- mem_addr  out  32  write address.
- mem_data  out  32  write data.
- mem_mask  out  4  write byte enables.
- mem_accepted  in  1  memory takes request this cycle.
- ld_valid  in  1  forwarding lookup.
- ld_addr  in  32  load word address.
- ld_sq_idx  in  IDX_W  queue tail captured at load dispatch.
- fwd_hit  out  1  all 4 load bytes supplied.
- fwd_data  out  32  forwarded word.
- fwd_stall  out  1  older store unresolved or partial overlap.
- count  out  IDX_W+1  occupied entries.

Function
REQ-006 SHALL keep per-entry state EMPTY, DISPATCHED, COMPLETED, RETIRED, plus addr, data, mask, rob_idx.
REQ-007 SHALL keep pointers head (oldest), ret_ptr (oldest non-retired), tail (next free), each with an extra wrap bit; full/empty by wrap-bit compare.
REQ-008 Dispatch: when disp_ready, each valid lane in lane order takes the next tail slot -> DISPATCHED; disp_sq_idx is combinational from current tail; disp_valid with disp_ready low SHALL be ignored.
REQ-009 Completion: cmpl_valid on a DISPATCHED slot writes addr/data/mask -> COMPLETED next cycle; on any other state SHALL be ignored.
REQ-010 Retire: k = count of ret_valid bits; entries ret_ptr..ret_ptr+k-1 SHALL be COMPLETED (caller guarantee) and become RETIRED; ret_ptr advances k.
REQ-011 Drain: mem_valid SHALL be high iff head entry is RETIRED, presenting its addr/data/mask; on mem_accepted head entry -> EMPTY, head advances 1; request held stable until accepted.
REQ-012 Flush: every non-RETIRED entry -> EMPTY, tail := ret_ptr next cycle; dispatch, completion, retire that cycle SHALL be ignored; drain continues.
REQ-013 Simultaneous dispatch, completion, retire, drain in one cycle SHALL all take effect; a slot freed by drain is allocatable the next cycle.
REQ-014 count SHALL equal tail minus head, modulo 2*SIZE, registered.
REQ-015 Wrap-around at SIZE-1 -> 0 SHALL toggle the wrap bit; all SIZE entries usable.

Reset
REQ-016 On reset all entries EMPTY, head = ret_ptr = tail = 0, count = 0, mem_valid = 0, fwd_hit = 0, fwd_stall = 0, fwd_data = 0, disp_ready = 1.
REQ-017 Reset mid-drain SHALL drop the request; memory sees mem_valid low next cycle.

Configuration
REQ-018 Macro SQ_FORWARD_EN defined: combinational lookup scans entries from head to ld_sq_idx (exclusive); youngest matching COMPLETED/RETIRED word supplies bytes; fwd_hit if its mask is 4'hF; fwd_stall if any DISPATCHED entry in range or youngest match mask partial.
REQ-019 Macro absent: no lookup logic; fwd_hit = 0, fwd_data = 0; fwd_stall = 1 whenever ld_valid and any non-EMPTY entry lies in range.

Verification
REQ-020 Dispatch 2 stores/cycle for 4 cycles, SIZE=8 -> disp_sq_idx 0..7, disp_ready 0 at count 8.
REQ-021 Complete slot 0 (addr 0x100, data 0xDEADBEEF, mask F), retire 1, mem_accepted high -> mem write 0x100/0xDEADBEEF one cycle after retire, count 7.
REQ-022 Flush with 3 retired and 2 dispatched -> tail = ret_ptr, count 3, three writes still drain.
REQ-023 SQ_FORWARD_EN, stores to 0x200 (0x11111111) then 0x200 (0x22222222), both completed, load at 0x200 -> fwd_hit 1, fwd_data 0x22222222.
REQ-024 SQ_FORWARD_EN, older store to 0x300 mask 4'h3 -> load 0x300 gets fwd_stall 1, fwd_hit 0.
REQ-025 Run 3*SIZE dispatch/retire/drain cycles -> pointers wrap, store order on memory port matches dispatch order.
